// File: rtl/rom_rd_arb.sv
// rom_rd_arb: two-port read arbiter in front of one synchronous ROM.
// Registered req/gnt handshake, round-robin arbitration, and a fixed-latency
// tag pipeline that routes each returned ROM word back to the port that issued it.
// Optional macro ROM_RD_ARB_FIXED_PRIO_EN: port 0 always wins a tie and the
// round-robin pointer is removed.
module rom_rd_arb #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int RD_LAT = 2
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              req0,
  input  logic [ADDR_W-1:0] addr0,
  output logic              gnt0,
  output logic              vld0,
  output logic [DATA_W-1:0] rdata0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr1,
  output logic              gnt1,
  output logic              vld1,
  output logic [DATA_W-1:0] rdata1,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_q,
  output logic              busy
);

  logic              elig0;
  logic              elig1;
  logic              grant_any;
  logic              pick1;
  logic [RD_LAT-1:0] tag_vld;
  logic [RD_LAT-1:0] tag_id;
  logic [RD_LAT-1:0] tag_vld_nxt;
  logic [RD_LAT-1:0] tag_id_nxt;
  logic              tail_vld;
  logic              tail_id;

`ifndef ROM_RD_ARB_FIXED_PRIO_EN
  logic              rr_ptr;  // 0: port 0 preferred, 1: port 1 preferred
`endif

  // Eligibility (a port is masked during its own grant cycle) and winner selection.
  always_comb begin
    // NOTE: every signal written here gets a value on every path, so no latch is inferred.
    elig0     = req0 & ~gnt0;
    elig1     = req1 & ~gnt1;
    grant_any = elig0 | elig1;
`ifdef ROM_RD_ARB_FIXED_PRIO_EN
    pick1     = elig1 & ~elig0;
`else
    pick1     = elig1 & (~elig0 | rr_ptr);
`endif
  end

  // Next state of the tag pipeline: stage 0 takes the new grant, the rest shift.
  always_comb begin
    tag_vld_nxt    = '0;
    tag_id_nxt     = '0;
    tag_vld_nxt[0] = grant_any;
    tag_id_nxt[0]  = pick1;
    for (int i = 1; i < RD_LAT; i++) begin
      tag_vld_nxt[i] = tag_vld[i-1];
      tag_id_nxt[i]  = tag_id[i-1];
    end
  end

  assign tail_vld = tag_vld[RD_LAT-1];
  assign tail_id  = tag_id[RD_LAT-1];

  // Grant pulses and the ROM address register; rom_addr holds when nobody is granted.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      gnt0     <= 1'b0;
      gnt1     <= 1'b0;
      rom_addr <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      gnt0 <= elig0 & ~pick1;
      gnt1 <= pick1;
      if (grant_any) begin
        rom_addr <= pick1 ? addr1 : addr0;
      end
    end
  end

`ifndef ROM_RD_ARB_FIXED_PRIO_EN
  // Round-robin pointer moves to the loser only when both ports competed.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rr_ptr <= 1'b0;
    end else if (elig0 && elig1) begin
      rr_ptr <= ~rr_ptr;
    end
  end
`endif

  // Tag pipeline and busy flag, registered together so busy tracks outstanding reads.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      // NOTE: the tag pipeline is reset, unlike a data RAM, because a stale valid bit would fire vld after reset.
      tag_vld <= '0;
      tag_id  <= '0;
      busy    <= 1'b0;
    end else begin
      tag_vld <= tag_vld_nxt;
      tag_id  <= tag_id_nxt;
      busy    <= |tag_vld_nxt;
    end
  end

  // Return path: the entry leaving the last stage captures rom_q for its port.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      vld0   <= 1'b0;
      vld1   <= 1'b0;
      rdata0 <= '0;
      rdata1 <= '0;
    end else begin
      vld0 <= tail_vld & ~tail_id;
      vld1 <= tail_vld & tail_id;
      if (tail_vld && !tail_id) begin
        rdata0 <= rom_q;
      end
      if (tail_vld && tail_id) begin
        rdata1 <= rom_q;
      end
    end
  end

endmodule

// File: tb/tb_rom_rd_arb.sv
// tb_rom_rd_arb: three instances (RD_LAT = 1, 2, 4) share one stimulus stream.
// A transaction-level reference model predicts grants, return data and busy.
module tb_rom_rd_arb;

  localparam int N = 3;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic       req0 = 1'b0;
  logic       req1 = 1'b0;
  logic [7:0] addr0 = 8'h00;
  logic [7:0] addr1 = 8'h00;

  logic       gnt0_w[N];
  logic       gnt1_w[N];
  logic       vld0_w[N];
  logic       vld1_w[N];
  logic       busy_w[N];
  logic [7:0] rdata0_w[N];
  logic [7:0] rdata1_w[N];
  logic [7:0] rom_addr_w[N];
  logic [7:0] rom_q_w[N];

  int errors = 0;
  int checks = 0;

  always #5 sys_clk = ~sys_clk;

  function automatic int lat(input int i);
    return (i == 0) ? 1 : ((i == 1) ? 2 : 4);
  endfunction

  // One DUT per latency, each with a ROM model returning addr+1 after RD_LAT edges.
  for (genvar gi = 0; gi < N; gi++) begin : g_dut
    localparam int L = (gi == 0) ? 1 : ((gi == 1) ? 2 : 4);
    logic [7:0] pipe[4];

    rom_rd_arb #(.ADDR_W(8), .DATA_W(8), .RD_LAT(L)) u_dut (
      .sys_clk  (sys_clk),
      .sys_rst_n(sys_rst_n),
      .req0     (req0),
      .addr0    (addr0),
      .gnt0     (gnt0_w[gi]),
      .vld0     (vld0_w[gi]),
      .rdata0   (rdata0_w[gi]),
      .req1     (req1),
      .addr1    (addr1),
      .gnt1     (gnt1_w[gi]),
      .vld1     (vld1_w[gi]),
      .rdata1   (rdata1_w[gi]),
      .rom_addr (rom_addr_w[gi]),
      .rom_q    (rom_q_w[gi]),
      .busy     (busy_w[gi])
    );

    always @(posedge sys_clk) begin
      pipe[0] <= rom_addr_w[gi];
      for (int j = 1; j < 4; j++) pipe[j] <= pipe[j-1];
    end

    if (L == 1) begin : g_comb
      assign rom_q_w[gi] = rom_addr_w[gi] + 8'd1;
    end else begin : g_reg
      assign rom_q_w[gi] = pipe[L-2] + 8'd1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got=%0h expected=%0h", tag, $time, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Grant history: index 0 = grant made at the latest edge, index k = k edges ago.
  bit         m_gnt0, m_gnt1, m_ptr;
  logic [7:0] m_rom_addr;
  bit         h_any[5];
  bit         h_port[5];
  logic [7:0] h_addr[5];
  logic [7:0] m_rd0[N];
  logic [7:0] m_rd1[N];

  task automatic model_reset();
    m_gnt0 = 0; m_gnt1 = 0; m_ptr = 0; m_rom_addr = 8'h00;
    for (int k = 0; k < 5; k++) begin h_any[k] = 0; h_port[k] = 0; h_addr[k] = 8'h00; end
    for (int i = 0; i < N; i++) begin m_rd0[i] = 8'h00; m_rd1[i] = 8'h00; end
  endtask

  // Apply the arbitration rules to the inputs present at this edge.
  task automatic model_edge();
    bit e0, e1, any, win;
    int L;
    e0  = req0 && !m_gnt0;
    e1  = req1 && !m_gnt1;
    any = e0 || e1;
    win = 0;
    if (e0 && e1) begin
`ifdef ROM_RD_ARB_FIXED_PRIO_EN
      win = 0;
`else
      win   = m_ptr;
      m_ptr = !m_ptr;
`endif
    end else if (e1) begin
      win = 1;
    end
    for (int k = 4; k > 0; k--) begin
      h_any[k] = h_any[k-1]; h_port[k] = h_port[k-1]; h_addr[k] = h_addr[k-1];
    end
    h_any[0]  = any;
    h_port[0] = win;
    h_addr[0] = win ? addr1 : addr0;
    m_gnt0    = any && !win;
    m_gnt1    = any && win;
    if (any) m_rom_addr = h_addr[0];
    for (int i = 0; i < N; i++) begin
      L = lat(i);
      if (h_any[L]) begin
        if (h_port[L]) m_rd1[i] = h_addr[L] + 8'd1;
        else           m_rd0[i] = h_addr[L] + 8'd1;
      end
    end
  endtask

  task automatic check_all();
    int L;
    bit eb;
    for (int i = 0; i < N; i++) begin
      L  = lat(i);
      eb = 0;
      for (int j = 0; j < L; j++) eb |= h_any[j];
      check($sformatf("gnt0_lat%0d", L), gnt0_w[i], m_gnt0);
      check($sformatf("gnt1_lat%0d", L), gnt1_w[i], m_gnt1);
      check($sformatf("rom_addr_lat%0d", L), rom_addr_w[i], m_rom_addr);
      check($sformatf("vld0_lat%0d", L), vld0_w[i], h_any[L] && !h_port[L]);
      check($sformatf("vld1_lat%0d", L), vld1_w[i], h_any[L] && h_port[L]);
      check($sformatf("rdata0_lat%0d", L), rdata0_w[i], m_rd0[i]);
      check($sformatf("rdata1_lat%0d", L), rdata1_w[i], m_rd1[i]);
      check($sformatf("busy_lat%0d", L), busy_w[i], eb);
    end
  endtask

  // ---------------- requesters ----------------
  logic [7:0] q0[$];
  logic [7:0] q1[$];
  bit act0, act1;
  bit rnd_gaps = 0;

  // A port whose grant was seen during the previous cycle retires its request now.
  task automatic retire();
    if (act0 && h_any[1] && !h_port[1]) begin
      void'(q0.pop_front()); act0 = 0; req0 = 0; addr0 = 8'($urandom);
    end
    if (act1 && h_any[1] && h_port[1]) begin
      void'(q1.pop_front()); act1 = 0; req1 = 0; addr1 = 8'($urandom);
    end
  endtask

  task automatic present();
    if (!act0 && q0.size() > 0 && (!rnd_gaps || $urandom_range(0, 2) != 0)) begin
      act0 = 1; req0 = 1; addr0 = q0[0];
    end
    if (!act1 && q1.size() > 0 && (!rnd_gaps || $urandom_range(0, 2) != 0)) begin
      act1 = 1; req1 = 1; addr1 = q1[0];
    end
  endtask

  task automatic step();
    @(posedge sys_clk);
    if (sys_rst_n) model_edge();
    #1;
    check_all();
    retire();
    present();
  endtask

  task automatic do_reset(input int cycles);
    sys_rst_n = 0;
    model_reset();
    q0.delete(); q1.delete();
    act0 = 0; act1 = 0; req0 = 0; req1 = 0;
    #1;
    check_all();
    repeat (cycles) step();
    sys_rst_n = 1;
  endtask

  function automatic logic [7:0] rnd_addr();
    case ($urandom_range(0, 5))
      0:       return 8'hFF;
      1:       return 8'h00;
      default: return 8'($urandom);
    endcase
  endfunction

  initial begin
    bit found;
    model_reset();
    repeat (2) @(posedge sys_clk);
    #1;
    check_all();
    sys_rst_n = 1;

    // Idle after reset.
    repeat (20) step();

    // Single port 0 read.
    q0.push_back(8'h10); present();
    repeat (8) step();

    // Both ports held: alternating grants.
    repeat (4) begin q0.push_back(8'hC0); q1.push_back(8'hA2); end
    present();
    repeat (16) step();

    // Reset one edge after a port 1 grant to address FF.
    q1.push_back(8'hFF); present();
    found = 0;
    for (int c = 0; c < 20 && !found; c++) begin
      step();
      found = h_any[0] && h_port[0];
    end
    check("t5_gnt1_seen", found, 1'b1);
    step();
    do_reset(3);
    repeat (8) step();

    // Back-to-back port 0 stream across the address wrap.
    q0.push_back(8'hFE); q0.push_back(8'hFF); q0.push_back(8'h00); present();
    repeat (12) step();

    // Random traffic with one reset in the middle.
    rnd_gaps = 1;
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 2) == 0 && q0.size() < 3) q0.push_back(rnd_addr());
      if ($urandom_range(0, 2) == 0 && q1.size() < 3) q1.push_back(rnd_addr());
      if (c == 300) do_reset(2);
      step();
    end
    rnd_gaps = 0;
    repeat (10) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rom_rd_arb.md
Name: rom_rd_arb

Overview:
Two-port read arbiter that shares one synchronous ROM between two requesters, for example an address stepper and a display scanner.
- Uses a registered req/gnt handshake and round-robin arbitration.
- Tracks in-flight reads in a fixed-latency tag pipeline, so each ROM word returns only to the port that issued it.
- Sits between the requesters and the ROM IP, and drives the ROM address bus.

Parameters:
ADDR_W, 8, ROM address width.
DATA_W, 8, ROM data width.
RD_LAT, 2, ROM read latency in clock edges from rom_addr registered to rom_q sampled (legal range 1..4).

Ports:
sys_clk    in   1       system clock, rising edge.
sys_rst_n  in   1       asynchronous reset, active low.
req0       in   1       port 0 read request; held with addr0 until gnt0 is seen.
addr0      in   ADDR_W  port 0 read address.
gnt0       out  1       port 0 grant; 1-cycle pulse.
vld0       out  1       port 0 read data valid; 1-cycle pulse.
rdata0     out  DATA_W  port 0 read data; holds until the next vld0.
req1       in   1       port 1 read request.
addr1      in   ADDR_W  port 1 read address.
gnt1       out  1       port 1 grant.
vld1       out  1       port 1 read data valid.
rdata1     out  DATA_W  port 1 read data.
rom_addr   out  ADDR_W  ROM address.
rom_q      in   DATA_W  ROM output data.
busy       out  1       high while any read is in flight.

Behaviour:
- Reset (asynchronous, sys_rst_n=0):
  - gnt0, gnt1, vld0, vld1, busy = 0.
  - rdata0, rdata1, rom_addr = 0.
  - Round-robin pointer = port 0 preferred.
  - Tag pipeline cleared.
- Eligibility: requester N is eligible at an edge when reqN=1 and gntN=0 (current cycle).
  - The cycle in which gntN=1 masks reqN, so req held one extra cycle is not re-granted.
  - A requester deasserts req, or presents a new address, in the cycle after seeing gnt.
- Grant at an edge. At most one grant per edge.
  - Neither eligible: gnt0=gnt1=0; rom_addr holds its value.
  - One eligible: grant it.
  - Both eligible: grant the preferred port, then move the pointer to the other port. The pointer updates only when both ports were eligible.
  - On a grant: gntN=1 for exactly one cycle, and rom_addr <= addrN at the same edge.
- Throughput: 1 read per cycle when ports alternate. A single port can be granted at most every 2nd cycle.
- Tag pipeline: RD_LAT stages of {valid, port_id}, shifted every edge. Stage 0 is loaded at the grant edge.
  - At the edge where the entry leaves the last stage (RD_LAT edges after the grant edge): rdataN <= rom_q and vldN=1 for one cycle.
  - With RD_LAT=2: gnt at edge k, vld and rdata at edge k+2.
- Ordering: data returns in grant order. Both vld outputs are never high in the same cycle.
- busy = OR of all tag-pipeline valid bits, registered with the pipeline. busy is 0 exactly when no read is outstanding.
- Reset mid-operation: all in-flight reads are discarded, with no vld pulse after reset release. rdata returns to 0.
- Address values: all 0..2^ADDR_W-1 are legal. There is no wrap-around logic; an address of 255 passes straight through.

Optional Feature:
Macro ROM_RD_ARB_FIXED_PRIO_EN.
- Defined: port 0 always wins when both ports are eligible. The round-robin pointer is not implemented. Port 1 is granted only when port 0 is not eligible, which includes the cycle after each gnt0.
- Undefined: round robin as described in Behaviour.

Test Plan:
1. Reset release, no requests, 20 cycles -> gnt/vld never pulse; busy=0; rom_addr=0.
2. req0 with addr0=8'h10 at edge 5, dropped after gnt0; ROM model returns addr+1 -> gnt0 at edge 5, vld0 at edge 7, rdata0=8'h11, busy high for edges 5..6.
3. req0 and req1 held for 8 cycles, addr0=8'hC0, addr1=8'hA2 -> grants alternate port0, port1, port0, ... one grant per edge; each vld matches its port; rdata0=8'hC1, rdata1=8'hA3.
4. Repeat scenario 3 with ROM_RD_ARB_FIXED_PRIO_EN defined -> gnt0 on even grant edges, gnt1 only in the masked cycles in between; no port 1 starvation beyond 1 cycle.
5. Assert sys_rst_n=0 one edge after gnt1 (addr1=8'hFF), release after 3 cycles -> no vld1, rdata1=0, busy=0.
6. Sweep RD_LAT=1 and RD_LAT=4 with a back-to-back addr0 stream 8'hFE, 8'hFF, 8'h00 -> vld0 at grant+RD_LAT each time; data 8'hFF, 8'h00, 8'h01 in order.
